// File: rtl/rf_writeback_ctrl_if.sv
// Bundle of write-back controller signals: ALU result input, load result input,
// register file write port and the status outputs.
interface rf_writeback_ctrl_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   alu_valid;
    logic [ADDR_W-1:0]      alu_rd;
    logic [DATA_W-1:0]      alu_data;
    // Load handshake: a transfer happens at a clock edge where mem_valid and
    // mem_ready are both high; mem_ready never depends on mem_valid, and a
    // source holding mem_valid keeps mem_rd/mem_data stable until accepted.
    logic                   mem_valid;
    logic                   mem_ready;
    logic [ADDR_W-1:0]      mem_rd;
    logic [DATA_W-1:0]      mem_data;
    logic                   writeReg;
    logic [ADDR_W-1:0]      write_reg_num;
    logic [DATA_W-1:0]      write_data;
    logic [(1<<ADDR_W)-1:0] pending_mask;
    logic [CNT_W-1:0]       fifo_count;
    logic                   order_err;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, writeReg, write_reg_num, write_data,
               pending_mask, fifo_count, order_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, writeReg, write_reg_num, write_data,
               pending_mask, fifo_count, order_err
    );
endinterface

// File: rtl/rf_writeback_ctrl.sv
// Merges ALU results and FIFO-buffered load results onto one register file write port.
// Optional macro RF_WB_ZERO_DISCARD_EN: results targeting register 0 are dropped.
module rf_writeback_ctrl #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    rf_writeback_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] num_q, num_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic              mem_ready;
    logic              push;
    logic              pop;
    logic              hazard;
    logic [NREG-1:0]   pending;

    assign mem_ready = (count_q < CNT_W'(DEPTH));
    assign push      = bus.mem_valid && mem_ready;
    assign pop       = !bus.alu_valid && (count_q != '0);

    // Entry at offset i from the head is live when i < count.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
`ifdef RF_WB_ZERO_DISCARD_EN
                if (rd_mem_q[rd_ptr_q + PTR_W'(i)] != '0)
                    pending[rd_mem_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
`else
                pending[rd_mem_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
`endif
            end
        end
    end

`ifdef RF_WB_ZERO_DISCARD_EN
    assign hazard = bus.alu_valid && pending[bus.alu_rd] && (bus.alu_rd != '0);
`else
    assign hazard = bus.alu_valid && pending[bus.alu_rd];
`endif

    always_comb begin
        we_d     = 1'b0;
        num_d    = num_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q | hazard;

        if (bus.alu_valid) begin
            we_d   = 1'b1;
            num_d  = bus.alu_rd;
            data_d = bus.alu_data;
        end else if (pop) begin
            we_d     = 1'b1;
            num_d    = rd_mem_q[rd_ptr_q];
            data_d   = data_mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
`ifdef RF_WB_ZERO_DISCARD_EN
        // The slot is still consumed; only the enable is suppressed.
        if (num_d == '0)
            we_d = 1'b0;
`endif
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            num_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            num_q    <= num_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: liveness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            rd_mem_q[wr_ptr_q]   <= bus.mem_rd;
            data_mem_q[wr_ptr_q] <= bus.mem_data;
        end
    end

    assign bus.mem_ready     = mem_ready;
    assign bus.writeReg      = we_q;
    assign bus.write_reg_num = num_q;
    assign bus.write_data    = data_q;
    assign bus.pending_mask  = pending;
    assign bus.fifo_count    = count_q;
    assign bus.order_err     = err_q;
endmodule
